// File: rtl/rom_rd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rom_rd_pkg                                                      |
// | Brief    : Shared types and default widths for the ROM read-port reader.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package rom_rd_pkg;

  localparam int C_W_DATA    = 16;
  localparam int C_W_ADDR    = 16;
  localparam int C_W_LEN     = 8;
  localparam int C_MAX_OUTST = 4;

  // Command word: len holds the word count minus one.
  typedef struct packed {
    logic [C_W_LEN-1:0]  len;
    logic [C_W_ADDR-1:0] base;
  } burst_cmd_t;

  typedef struct packed {
    logic                last;
    logic [C_W_DATA-1:0] word;
  } rd_out_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_t;

endpackage
`default_nettype wire

// File: rtl/dti.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dti                                                             |
// | Brief    : Valid/ready data-transfer interface with producer/consumer views.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface dti #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rom_burst_reader                                                |
// | Brief    : Turns a {len, base} burst command into ROM reads and forwards   |
// |            returned words downstream tagged with an end-of-burst flag.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rom_burst_reader
  import rom_rd_pkg::*;
#(
  parameter int W_DATA    = C_W_DATA,
  parameter int W_ADDR    = C_W_ADDR,
  parameter int W_LEN     = C_W_LEN,
  parameter int MAX_OUTST = C_MAX_OUTST
) (
  input  logic clk,
  input  logic rst,
  dti.consumer cmd_if,
  dti.producer addr_if,
  dti.consumer data_if,
  dti.producer dout_if
);

  localparam int                 W_OUTST     = $clog2(MAX_OUTST) + 1;
  localparam logic [W_OUTST-1:0] C_OUTST_MAX = W_OUTST'(MAX_OUTST);

  reader_state_t      r_state;
  reader_state_t      w_state_nxt;
  logic [W_ADDR-1:0]  r_cur_addr;
  logic [W_LEN-1:0]   r_len;
  logic [W_LEN-1:0]   r_issued_cnt;
  logic [W_LEN-1:0]   r_recv_cnt;
  logic [W_OUTST-1:0] r_outst_cnt;

  logic w_busy;
  logic w_last;
  logic w_cmd_xfer;
  logic w_addr_xfer;
  logic w_data_xfer;

  assign w_busy = (r_state != ST_IDLE);
  assign w_last = (r_recv_cnt == r_len);

  // Gated by rst so ready drops the moment reset asserts, not at the next edge.
  assign cmd_if.ready  = rst && (r_state == ST_IDLE);
  assign addr_if.valid = (r_state == ST_ISSUE) && (r_outst_cnt < C_OUTST_MAX);
  assign addr_if.data  = r_cur_addr;
  assign data_if.ready = w_busy && dout_if.ready;
  assign dout_if.valid = w_busy && data_if.valid;
  assign dout_if.data  = {w_last, data_if.data};

  assign w_cmd_xfer  = cmd_if.valid  && cmd_if.ready;
  assign w_addr_xfer = addr_if.valid && addr_if.ready;
  assign w_data_xfer = data_if.valid && data_if.ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_xfer) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_addr_xfer && (r_issued_cnt == r_len)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_DRAIN;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // The final beat ends the burst from whichever busy state we are in.
    if (w_data_xfer && w_last) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cur_addr   <= '0;
      r_len        <= '0;
      r_issued_cnt <= '0;
      r_recv_cnt   <= '0;
      r_outst_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_xfer) begin
        r_cur_addr   <= cmd_if.data[W_ADDR-1:0];
        r_len        <= cmd_if.data[W_LEN+W_ADDR-1:W_ADDR];
        r_issued_cnt <= '0;
        r_recv_cnt   <= '0;
        r_outst_cnt  <= '0;
      end else begin
        if (w_addr_xfer) begin
          r_cur_addr   <= r_cur_addr + W_ADDR'(1);
          r_issued_cnt <= r_issued_cnt + W_LEN'(1);
        end
        if (w_data_xfer) begin
          r_recv_cnt <= r_recv_cnt + W_LEN'(1);
        end
        case ({w_addr_xfer, w_data_xfer})
          2'b10:   r_outst_cnt <= r_outst_cnt + W_OUTST'(1);
          2'b01:   r_outst_cnt <= r_outst_cnt - W_OUTST'(1);
          default: r_outst_cnt <= r_outst_cnt;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
